// File: rtl/rtl_handshake_source.sv
// Transmit side of a ready/valid channel: reduces each 4-bit word (|, &, and-of-both)
// and presents it downstream through a 2-entry skid buffer with registered outputs.
module rtl_handshake_source #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             handshake_valid,
  input  logic             handshake_ready,
  output logic             out,
  output logic [WIDTH-1:0] out_in2,
  output logic             mon_temp1,
  output logic             mon_temp2,
  output logic [CNT_W-1:0] sent_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] head_in2_q, head_in2_d, skid_in2_q, skid_in2_d;
  logic             head_t1_q, head_t1_d, head_t2_q, head_t2_d;
  logic             skid_t1_q, skid_t1_d, skid_t2_q, skid_t2_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop, new_t1, new_t2;
  logic             load_head_new, load_head_skid, load_skid;

  assign new_t1 = |in1;
  assign new_t2 = &in1;
  assign push   = in_valid & in_ready_q;
  assign pop    = handshake_valid & handshake_ready;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d       = ONE;
          load_head_new = 1'b1;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (!push && pop) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          load_head_new = 1'b1;
        end
      end
      FULL: begin
        if (pop) begin
          state_d        = ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Ready reflects the occupancy after this edge, so it never depends on handshake_ready combinationally.
    in_ready_d = (state_d != FULL);
  end

  always_comb begin
    handshake_valid = (state_q != EMPTY);
  end

  always_comb begin
    head_in2_d = head_in2_q;
    head_t1_d  = head_t1_q;
    head_t2_d  = head_t2_q;
    skid_in2_d = skid_in2_q;
    skid_t1_d  = skid_t1_q;
    skid_t2_d  = skid_t2_q;
    if (load_head_new) begin
      head_in2_d = in2;
      head_t1_d  = new_t1;
      head_t2_d  = new_t2;
    end else if (load_head_skid) begin
      head_in2_d = skid_in2_q;
      head_t1_d  = skid_t1_q;
      head_t2_d  = skid_t2_q;
    end
    if (load_skid) begin
      skid_in2_d = in2;
      skid_t1_d  = new_t1;
      skid_t2_d  = new_t2;
    end
    out_d = head_t1_d & head_t2_d;
    cnt_d = cnt_q + CNT_W'(pop);
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      head_in2_q <= '0;
      head_t1_q  <= 1'b0;
      head_t2_q  <= 1'b0;
      skid_in2_q <= '0;
      skid_t1_q  <= 1'b0;
      skid_t2_q  <= 1'b0;
      out_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      head_in2_q <= head_in2_d;
      head_t1_q  <= head_t1_d;
      head_t2_q  <= head_t2_d;
      skid_in2_q <= skid_in2_d;
      skid_t1_q  <= skid_t1_d;
      skid_t2_q  <= skid_t2_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out        = out_q;
  assign out_in2    = head_in2_q;
  assign mon_temp1  = head_t1_q;
  assign mon_temp2  = head_t2_q;
  assign sent_count = cnt_q;

endmodule

// File: tb/tb_rtl_handshake_source.sv
// Bench for rtl_handshake_source: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rtl_handshake_source;

  logic       CLK = 1'b0;
  logic       ASYNCRESETN = 1'b1;
  logic       in_valid = 1'b0;
  logic       handshake_ready = 1'b0;
  logic [3:0] in1 = 4'h0;
  logic [3:0] in2 = 4'h0;

  logic        in_ready, handshake_valid, out, mon_temp1, mon_temp2;
  logic [3:0]  out_in2;
  logic [15:0] sent_count;

  logic        w_in_ready, w_valid, w_out, w_t1, w_t2;
  logic [3:0]  w_in2;
  logic [3:0]  w_sent;

  int tests_run = 0;
  int fails = 0;

  rtl_handshake_source #(.WIDTH(4), .CNT_W(16)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .handshake_valid(handshake_valid), .handshake_ready(handshake_ready),
    .out(out), .out_in2(out_in2), .mon_temp1(mon_temp1), .mon_temp2(mon_temp2),
    .sent_count(sent_count)
  );

  rtl_handshake_source #(.WIDTH(4), .CNT_W(4)) dut4 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .in_valid(in_valid), .in_ready(w_in_ready), .in1(in1), .in2(in2),
    .handshake_valid(w_valid), .handshake_ready(handshake_ready),
    .out(w_out), .out_in2(w_in2), .mon_temp1(w_t1), .mon_temp2(w_t2),
    .sent_count(w_sent)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of accepted words, capacity 2.
  typedef struct packed {
    logic [3:0] in2;
    logic [3:0] in1;
  } beat_t;
  beat_t q[$];
  logic       m_in_ready;
  logic [3:0] m_in2;
  logic       m_t1, m_t2;
  int         m_sent;
  bit         push_m, pop_m;

  initial begin
    m_in_ready = 1'b0; m_in2 = 4'h0; m_t1 = 1'b0; m_t2 = 1'b0; m_sent = 0;
    forever begin
      @(posedge CLK or negedge ASYNCRESETN);
      if (!ASYNCRESETN) begin
        q.delete();
        m_in_ready = 1'b0; m_in2 = 4'h0; m_t1 = 1'b0; m_t2 = 1'b0; m_sent = 0;
      end else begin
        push_m = in_valid && m_in_ready;
        pop_m  = (q.size() > 0) && handshake_ready;
        if (pop_m) begin
          $display("[TB] beat %0d sent: in1=%h in2=%h", m_sent, q[0].in1, q[0].in2);
          void'(q.pop_front());
          m_sent++;
        end
        if (push_m) q.push_back({in2, in1});
        if (q.size() > 0) begin
          m_in2 = q[0].in2;
          m_t1  = |q[0].in1;
          m_t2  = &q[0].in1;
        end
        m_in_ready = (q.size() < 2);
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      check("valid", {31'd0, handshake_valid}, {31'd0, q.size() > 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
      check("out", {31'd0, out}, {31'd0, m_t1 & m_t2});
      check("out_in2", {28'd0, out_in2}, {28'd0, m_in2});
      check("mon_temp1", {31'd0, mon_temp1}, {31'd0, m_t1});
      check("mon_temp2", {31'd0, mon_temp2}, {31'd0, m_t2});
      check("sent_count", {16'd0, sent_count}, m_sent & 32'hFFFF);
      check("sent_count4", {28'd0, w_sent}, m_sent & 32'hF);
      check("valid4", {31'd0, w_valid}, {31'd0, q.size() > 0});
      if (handshake_valid) check("monitor", {31'd0, out}, {31'd0, mon_temp1 && mon_temp2});
    end
  end

  task automatic push_word(input logic [3:0] a, input logic [3:0] b);
    in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  int seen;

  initial begin
    // reset held with in_valid asserted
    in_valid = 1'b1; in1 = 4'hF; handshake_ready = 1'b1;
    #1 ASYNCRESETN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", {31'd0, handshake_valid}, 32'd0);
    check("rst_count", {16'd0, sent_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    ASYNCRESETN = 1'b1; in_valid = 1'b0;
    @(posedge CLK); #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // single beats with ready=1
    push_word(4'hF, 4'h5);
    check("t2_F_out", {31'd0, out}, 32'd1);
    check("t2_F_t1", {31'd0, mon_temp1}, 32'd1);
    check("t2_F_t2", {31'd0, mon_temp2}, 32'd1);
    check("t2_F_in2", {28'd0, out_in2}, 32'h5);
    push_word(4'h3, 4'hA);
    check("t2_3_out", {31'd0, out}, 32'd0);
    check("t2_3_t1", {31'd0, mon_temp1}, 32'd1);
    check("t2_3_t2", {31'd0, mon_temp2}, 32'd0);
    push_word(4'h0, 4'hC);
    check("t2_0_out", {31'd0, out}, 32'd0);
    check("t2_0_t1", {31'd0, mon_temp1}, 32'd0);
    check("t2_0_t2", {31'd0, mon_temp2}, 32'd0);
    @(posedge CLK); #1;
    check("t2_count", {16'd0, sent_count}, 32'd3);

    // backpressure fills the skid entry
    handshake_ready = 1'b0;
    in1 = 4'hF; in2 = 4'h1; in_valid = 1'b1;
    @(posedge CLK); #1;
    in1 = 4'h1; in2 = 4'h2;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    check("t3_full_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      check("t3_stall_out", {31'd0, out}, 32'd1);
      check("t3_stall_valid", {31'd0, handshake_valid}, 32'd1);
    end
    handshake_ready = 1'b1;
    @(posedge CLK); #1;
    check("t3_second_out", {31'd0, out}, 32'd0);
    check("t3_second_in2", {28'd0, out_in2}, 32'h2);
    check("t3_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge CLK); #1;
    check("t3_drained", {31'd0, handshake_valid}, 32'd0);
    check("t3_count", {16'd0, sent_count}, 32'd5);

    // full throughput, 100 words
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      in1 = i[3:0]; in2 = ~i[3:0]; in_valid = 1'b1;
      @(posedge CLK); #1;
      if (handshake_valid && handshake_ready) seen++;
      check("t4_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    @(posedge CLK); #1;
    check("t4_beats", seen, 32'd100);
    check("t4_count", {16'd0, sent_count}, 32'd105);
    check("t4_count4", {28'd0, w_sent}, 32'd9);

    // async reset while FULL
    handshake_ready = 1'b0;
    in1 = 4'hA; in2 = 4'h3; in_valid = 1'b1;
    @(posedge CLK); #1;
    in1 = 4'hF; in2 = 4'h7;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    check("t5_full", {31'd0, in_ready}, 32'd0);
    #2 ASYNCRESETN = 1'b0;
    #1;
    check("t5_valid", {31'd0, handshake_valid}, 32'd0);
    check("t5_out", {31'd0, out}, 32'd0);
    check("t5_in2", {28'd0, out_in2}, 32'd0);
    check("t5_taps", {30'd0, mon_temp1, mon_temp2}, 32'd0);
    check("t5_count", {16'd0, sent_count}, 32'd0);
    check("t5_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 ASYNCRESETN = 1'b1; handshake_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      check("t5_no_stale", {31'd0, handshake_valid}, 32'd0);
    end

    // counter wrap on the CNT_W=4 instance
    for (int i = 0; i < 17; i++) begin
      in1 = 4'(i * 3); in2 = i[3:0]; in_valid = 1'b1;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    @(posedge CLK); #1;
    check("t6_count4_wrap", {28'd0, w_sent}, 32'd1);
    check("t6_count16", {16'd0, sent_count}, 32'd17);

    @(posedge CLK); #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
